traffic_light_fsm: RTL

- Intersection controller that consumes the debounced (clean) pedestrian button and side-street vehicle sensor levels.
- Sequences the main-street lights, side-street lights and walk lamp using a tick-based state timer.
- Sits directly downstream of the debouncers; its light outputs drive the lamp/LED drivers.

---
 rtl/traffic_light_fsm.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/traffic_light_fsm.sv
// Intersection controller: sequences main/side lamps and the walk lamp from a
// tick-based state timer, driven by debounced walk-button and sensor levels.
module traffic_light_fsm #(
    parameter int TICK_CYCLES = 27000000,
    parameter int T_BASE      = 6,
    parameter int T_EXT       = 3,
    parameter int T_YEL       = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       walk_btn,
    input  logic       sensor,
    output logic [2:0] main_rgy,
    output logic [2:0] side_rgy,
    output logic       walk_light,
    output logic       walk_pending,
    output logic [2:0] state_out,
    output logic [7:0] ticks_left
);

    typedef enum logic [2:0] {
        MAIN_BASE = 3'd0,
        MAIN_EXT  = 3'd1,
        MAIN_YEL  = 3'd2,
        WALK      = 3'd3,
        SIDE_BASE = 3'd4,
        SIDE_EXT  = 3'd5,
        SIDE_YEL  = 3'd6
    } state_t;

    // Prescaler wide enough for the largest legal TICK_CYCLES (2^25-1).
    localparam int             PW         = 25;
    localparam logic [PW-1:0]  PRESC_MAX  = PW'(TICK_CYCLES - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
    localparam logic [7:0]     LOAD_BASE  = 8'(T_BASE - 1);
    localparam logic [7:0]     LOAD_EXT   = 8'(T_EXT - 1);
    localparam logic [7:0]     LOAD_YEL   = 8'(T_YEL - 1);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    tick_q, tick_d;
    logic          walk_prev_q, walk_prev_d;
    logic          walk_pending_q, walk_pending_d;

    logic wrap;
    logic expire;
    logic entering;
    logic walk_rise;

    function automatic logic [7:0] load_of(input state_t s);
        case (s)
            MAIN_BASE, SIDE_BASE:  load_of = LOAD_BASE;
            MAIN_EXT, SIDE_EXT,
            WALK:                  load_of = LOAD_EXT;
            MAIN_YEL, SIDE_YEL:    load_of = LOAD_YEL;
            default:               load_of = LOAD_BASE;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can hold
    // its old value, which would infer a latch.
    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        tick_d         = tick_q;
        walk_prev_d    = walk_btn;
        walk_pending_d = walk_pending_q;

        wrap      = (presc_q == PRESC_MAX);
        expire    = wrap && (tick_q == 8'd0);
        walk_rise = walk_btn && !walk_prev_q;

        case (state_q)
            MAIN_BASE: if (expire) state_d = sensor ? MAIN_EXT : MAIN_YEL;
            MAIN_EXT:  if (expire) state_d = MAIN_YEL;
            MAIN_YEL:  if (expire) state_d = walk_pending_q ? WALK : SIDE_BASE;
            WALK:      if (expire) state_d = SIDE_BASE;
            SIDE_BASE: if (expire) state_d = sensor ? SIDE_EXT : SIDE_YEL;
            SIDE_EXT:  if (expire) state_d = SIDE_YEL;
            SIDE_YEL:  if (expire) state_d = MAIN_BASE;
            default:   state_d = MAIN_BASE;
        endcase

        // Any change of state restarts the timer with the new state's length.
        entering = (state_d != state_q);
        if (entering) begin
            presc_d = '0;
            tick_d  = load_of(state_d);
        end else if (wrap) begin
            presc_d = '0;
            if (tick_q != 8'd0) tick_d = tick_q - 8'd1;
        end else begin
            presc_d = presc_q + PRESC_ONE;
        end

        // Entry into WALK wins over a coincident edge; edges inside WALK are lost.
        if (state_d == WALK && state_q != WALK) begin
            walk_pending_d = 1'b0;
        end else if (walk_rise && state_q != WALK) begin
            walk_pending_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= MAIN_BASE;
            presc_q        <= '0;
            tick_q         <= LOAD_BASE;
            walk_prev_q    <= 1'b1;
            walk_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            tick_q         <= tick_d;
            walk_prev_q    <= walk_prev_d;
            walk_pending_q <= walk_pending_d;
        end
    end

    // Lamp decode is purely from the registered state, so it cannot glitch.
    always_comb begin
        main_rgy   = LAMP_RED;
        side_rgy   = LAMP_RED;
        walk_light = 1'b0;
        case (state_q)
            MAIN_BASE, MAIN_EXT:  main_rgy = LAMP_GRN;
            MAIN_YEL:             main_rgy = LAMP_YEL;
            WALK:                 walk_light = 1'b1;
            SIDE_BASE, SIDE_EXT:  side_rgy = LAMP_GRN;
            SIDE_YEL:             side_rgy = LAMP_YEL;
            default: begin
                main_rgy = LAMP_RED;
                side_rgy = LAMP_RED;
            end
        endcase
    end

    assign walk_pending = walk_pending_q;
    assign state_out    = state_q;
    assign ticks_left   = tick_q + 8'd1;

endmodule
